mem_access_sequencer: RTL and testbench

- Parametrised data-memory access engine for the MEM stage of the LC-3b pipeline.
- Accepts one load/store request at a time, performs zero or more pointer-indirection reads (LDI/STI generalised to N levels), then the final word or byte access.
- Drives the d_mem handshake, raises stall while busy, and returns load data to WB.
- Replaces the ad-hoc LDI/STI inter-stage muxing with a single sequenced block.

---
 rtl/mem_access_sequencer.sv | 94 +++++++++
 tb/tb_mem_access_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: MEM-stage load/store engine with N-level pointer indirection (req_* in, d_mem_* handshake, stall_o, rsp_* out)
module mem_access_sequencer #(
  parameter int WIDTH = 16,
  parameter int MAX_IND = 1,
  localparam int NB = WIDTH / 8,
  localparam int LW = $clog2(NB),
  localparam int IW = $clog2(MAX_IND + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_store_i,
  input  logic             req_byte_i,
  input  logic [IW-1:0]    req_ind_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] d_mem_address_o,
  output logic [WIDTH-1:0] d_mem_wdata_o,
  output logic             d_mem_read_o,
  output logic             d_mem_write_o,
  output logic [NB-1:0]    d_mem_byte_enable_o,
  input  logic             d_mem_resp_i,
  input  logic [WIDTH-1:0] d_mem_rdata_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_rdata_o
);
  typedef enum logic [2:0] {IDLE, PTR, ACCESS, DRAIN, DONE} state_t;
  state_t state_q;
  logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic store_q, byte_q, drain_ptr_q;
  logic [IW-1:0] cnt_q, ind_clamp;
  logic [LW-1:0] lane;
  logic [7:0] rd_byte;
  logic ptr_ph, acc_ph, wr;
  assign ind_clamp = (req_ind_i > IW'(MAX_IND)) ? IW'(MAX_IND) : req_ind_i;
  assign lane = addr_q[LW-1:0];
  assign rd_byte = d_mem_rdata_i[{lane, 3'b000} +: 8];
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      store_q <= 1'b0;
      byte_q <= 1'b0;
      drain_ptr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i && !flush_i) begin
          addr_q <= req_addr_i;
          wdata_q <= req_wdata_i;
          store_q <= req_store_i;
          byte_q <= req_byte_i;
          cnt_q <= ind_clamp;
          rdata_q <= '0;
          state_q <= (ind_clamp != '0) ? PTR : ACCESS;
        end
        PTR: if (flush_i) begin
          drain_ptr_q <= 1'b1;
          state_q <= d_mem_resp_i ? IDLE : DRAIN;
        end else if (d_mem_resp_i) begin
          addr_q <= d_mem_rdata_i;
          cnt_q <= cnt_q - IW'(1);
          if (cnt_q == IW'(1)) state_q <= ACCESS;
        end
        ACCESS: if (flush_i) begin
          drain_ptr_q <= 1'b0;
          state_q <= d_mem_resp_i ? IDLE : DRAIN;
        end else if (d_mem_resp_i) begin
          if (!store_q) rdata_q <= byte_q ? WIDTH'(rd_byte) : d_mem_rdata_i;
          state_q <= DONE;
        end
        DRAIN: if (d_mem_resp_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ptr_ph = state_q == PTR || (state_q == DRAIN && drain_ptr_q);
  assign acc_ph = state_q == ACCESS || (state_q == DRAIN && !drain_ptr_q);
  assign wr = acc_ph && store_q;
  assign req_ready_o = state_q == IDLE;
  assign stall_o = ptr_ph || acc_ph;
  assign d_mem_read_o = ptr_ph || (acc_ph && !store_q);
  assign d_mem_write_o = wr;
  assign d_mem_address_o = stall_o ? addr_q : '0;
  assign d_mem_wdata_o = !wr ? '0 : byte_q ? {NB{wdata_q[7:0]}} : wdata_q;
  assign d_mem_byte_enable_o = !wr ? '0 : byte_q ? NB'(1) << lane : '1;
  assign rsp_valid_o = state_q == DONE;
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: randomized and directed checks of mem_access_sequencer against a memory model
module tb_mem_access_sequencer;
  typedef struct {logic [15:0] a; logic w; logic [15:0] d; logic [1:0] be;} txn_t;
  logic clk = 1'b0;
  logic reset, req_valid, req_store, req_byte, flush, d_mem_resp;
  logic [1:0] req_ind;
  logic [15:0] req_addr, req_wdata, d_mem_rdata;
  logic req_ready, stall, d_mem_read, d_mem_write, rsp_valid;
  logic [15:0] d_mem_address, d_mem_wdata, rsp_rdata;
  logic [1:0] d_mem_byte_enable;
  int n_checks = 0, n_pass = 0, lat_cfg = 0, left = 0;
  bit busy = 0;
  logic [15:0] mem [0:32767];
  txn_t log_q[$];
  mem_access_sequencer #(.WIDTH(16), .MAX_IND(2)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_store_i(req_store), .req_byte_i(req_byte), .req_ind_i(req_ind), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .flush_i(flush), .stall_o(stall), .d_mem_address_o(d_mem_address),
    .d_mem_wdata_o(d_mem_wdata), .d_mem_read_o(d_mem_read), .d_mem_write_o(d_mem_write),
    .d_mem_byte_enable_o(d_mem_byte_enable), .d_mem_resp_i(d_mem_resp), .d_mem_rdata_i(d_mem_rdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata)
  );
  always #5 clk = ~clk;
  initial begin
    d_mem_resp = 0;
    d_mem_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!(d_mem_read || d_mem_write)) begin
        busy = 0;
        d_mem_resp = 0;
      end else begin
        if (!busy || d_mem_resp) begin busy = 1; left = lat_cfg; end
        if (left == 0) begin
          d_mem_resp = 1;
          log_q.push_back('{d_mem_address, d_mem_write, d_mem_wdata, d_mem_byte_enable});
          if (d_mem_write) begin
            if (d_mem_byte_enable[0]) mem[d_mem_address[15:1]][7:0] = d_mem_wdata[7:0];
            if (d_mem_byte_enable[1]) mem[d_mem_address[15:1]][15:8] = d_mem_wdata[15:8];
          end else d_mem_rdata = mem[d_mem_address[15:1]];
        end else begin
          left--;
          d_mem_resp = 0;
        end
      end
      if (!d_mem_resp || d_mem_write) d_mem_rdata = 16'($urandom);
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic run_req(input string nm, input bit st, input bit by, input logic [1:0] ind,
                         input logic [15:0] addr, input logic [15:0] wd, input int lat);
    txn_t exp_q[$];
    logic [15:0] a, er, w, nw;
    int n, k, sb;
    bit got;
    n = (ind > 2) ? 2 : int'(ind);
    a = addr;
    er = 0;
    nw = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{a, 1'b0, 16'h0, 2'b00});
      a = mem[a[15:1]];
    end
    w = mem[a[15:1]];
    if (!st) begin
      er = !by ? w : a[0] ? {8'h0, w[15:8]} : {8'h0, w[7:0]};
      exp_q.push_back('{a, 1'b0, 16'h0, 2'b00});
    end else begin
      nw = !by ? wd : a[0] ? {wd[7:0], w[7:0]} : {w[15:8], wd[7:0]};
      exp_q.push_back('{a, 1'b1, by ? {wd[7:0], wd[7:0]} : wd, !by ? 2'b11 : a[0] ? 2'b10 : 2'b01});
    end
    lat_cfg = lat;
    log_q.delete();
    req_valid = 1; req_store = st; req_byte = by; req_ind = ind; req_addr = addr; req_wdata = wd;
    step();
    req_valid = 0;
    k = 0; sb = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (rsp_valid) got = 1;
      else begin
        if (!stall) sb++;
        step();
        k++;
      end
    end
    n_checks++; if (got !== 1'b1) $display("FAIL %s rsp_seen: got %0b want 1", nm, got); else n_pass++;
    n_checks++; if (k != (n + 1) * (lat + 1)) $display("FAIL %s latency: got %0d want %0d", nm, k, (n + 1) * (lat + 1)); else n_pass++;
    n_checks++; if (sb != 0) $display("FAIL %s stall_busy: got %0d low cycles want 0", nm, sb); else n_pass++;
    n_checks++; if (rsp_rdata !== er) $display("FAIL %s rsp_rdata: got %h want %h", nm, rsp_rdata, er); else n_pass++;
    n_checks++; if ({req_ready, stall} !== 2'b00) $display("FAIL %s done_ready_stall: got %b want 00", nm, {req_ready, stall}); else n_pass++;
    n_checks++; if (log_q.size() != exp_q.size()) $display("FAIL %s txn_count: got %0d want %0d", nm, log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i].a !== exp_q[i].a || log_q[i].w !== exp_q[i].w || log_q[i].be !== exp_q[i].be || (exp_q[i].w && log_q[i].d !== exp_q[i].d))
        $display("FAIL %s txn%0d: got a=%h w=%b d=%h be=%b want a=%h w=%b d=%h be=%b", nm, i,
                 log_q[i].a, log_q[i].w, log_q[i].d, log_q[i].be, exp_q[i].a, exp_q[i].w, exp_q[i].d, exp_q[i].be);
      else n_pass++;
    end
    step();
    n_checks++; if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL %s after_done: got ready,valid=%b want 10", nm, {req_ready, rsp_valid}); else n_pass++;
    if (st) begin
      n_checks++; if (mem[a[15:1]] !== nw) $display("FAIL %s mem_after: got %h want %h", nm, mem[a[15:1]], nw); else n_pass++;
    end
  endtask
  task automatic test_reset();
    reset = 1;
    step();
    step();
    reset = 0;
    n_checks++; if ({req_ready, stall, d_mem_read, d_mem_write, rsp_valid} !== 5'b10000) $display("FAIL reset_flags: got %b want 10000", {req_ready, stall, d_mem_read, d_mem_write, rsp_valid}); else n_pass++;
    n_checks++; if ({d_mem_address, d_mem_wdata, rsp_rdata, d_mem_byte_enable} !== 50'h0) $display("FAIL reset_buses: got a=%h d=%h r=%h be=%b want 0", d_mem_address, d_mem_wdata, rsp_rdata, d_mem_byte_enable); else n_pass++;
  endtask
  task automatic test_directed();
    mem[16'h1000 >> 1] = 16'hBEEF;
    mem[16'h2000 >> 1] = 16'hA55A;
    run_req("word_load", 0, 0, 0, 16'h1000, 16'h0, 2);
    run_req("direct_fast", 0, 0, 0, 16'h1000, 16'h0, 0);
    run_req("byte_load_odd", 0, 1, 0, 16'h2001, 16'h0, 1);
    run_req("byte_load_even", 0, 1, 0, 16'h2000, 16'h0, 0);
    run_req("byte_store", 1, 1, 0, 16'h3003, 16'h1234, 1);
    run_req("word_store", 1, 0, 0, 16'h3002, 16'h1234, 0);
  endtask
  task automatic test_indirect();
    mem[16'h0100 >> 1] = 16'h0200;
    mem[16'h0200 >> 1] = 16'h0300;
    mem[16'h0300 >> 1] = 16'h7777;
    run_req("ind_load", 0, 0, 2, 16'h0100, 16'h0, 1);
    run_req("ind_store", 1, 0, 2, 16'h0100, 16'h9999, 0);
    run_req("ind_clamp", 0, 0, 3, 16'h0100, 16'h0, 0);
  endtask
  task automatic test_flush();
    int bad, steps;
    mem[16'h0A00 >> 1] = 16'h4321;
    req_valid = 1; flush = 1; req_store = 0; req_byte = 0; req_ind = 0; req_addr = 16'h0A00;
    step();
    req_valid = 0; flush = 0;
    n_checks++; if ({req_ready, d_mem_read, stall} !== 3'b100) $display("FAIL flush_idle: got %b want 100", {req_ready, d_mem_read, stall}); else n_pass++;
    lat_cfg = 2;
    req_valid = 1;
    step();
    req_valid = 0; flush = 1;
    step();
    flush = 0;
    n_checks++; if ({d_mem_read, d_mem_address} !== {1'b1, 16'h0A00}) $display("FAIL flush_drain_hold: got rd=%b a=%h want 1 0a00", d_mem_read, d_mem_address); else n_pass++;
    bad = 0; steps = 0;
    for (int i = 0; i < 20 && !d_mem_resp; i++) begin
      if (!d_mem_read || rsp_valid) bad++;
      step();
      steps++;
    end
    n_checks++; if (steps != 1) $display("FAIL flush_resp_time: got %0d want 1", steps); else n_pass++;
    n_checks++; if ({bad[0], d_mem_read} !== 2'b01 || bad != 0) $display("FAIL flush_strobe_held: got bad=%0d rd=%b want 0 1", bad, d_mem_read); else n_pass++;
    step();
    n_checks++; if ({req_ready, d_mem_read, rsp_valid, stall} !== 4'b1000) $display("FAIL flush_release: got %b want 1000", {req_ready, d_mem_read, rsp_valid, stall}); else n_pass++;
    step();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL flush_no_rsp: got %b want 0", rsp_valid); else n_pass++;
    for (int p = 0; p < 2; p++) begin
      lat_cfg = 0;
      req_ind = 2'(p);
      req_valid = 1;
      step();
      req_valid = 0;
      flush = d_mem_resp;
      step();
      flush = 0;
      n_checks++; if ({req_ready, rsp_valid, stall, d_mem_read} !== 4'b1000) $display("FAIL flush_coincident%0d: got %b want 1000", p, {req_ready, rsp_valid, stall, d_mem_read}); else n_pass++;
      step();
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL flush_coincident_rsp%0d: got %b want 0", p, rsp_valid); else n_pass++;
    end
    req_ind = 0;
  endtask
  task automatic test_reset_mid_ptr();
    lat_cfg = 5;
    req_valid = 1; req_store = 0; req_byte = 0; req_ind = 2; req_addr = 16'h0100;
    step();
    req_valid = 0;
    step();
    n_checks++; if ({d_mem_read, stall} !== 2'b11) $display("FAIL ptr_active: got %b want 11", {d_mem_read, stall}); else n_pass++;
    reset = 1;
    step();
    reset = 0;
    n_checks++; if ({d_mem_read, d_mem_write, req_ready, rsp_valid, stall} !== 5'b00100) $display("FAIL reset_mid_ptr: got %b want 00100", {d_mem_read, d_mem_write, req_ready, rsp_valid, stall}); else n_pass++;
    run_req("after_reset", 0, 0, 2, 16'h0100, 16'h0, 1);
  endtask
  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_req("rand", 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
  endtask
  initial begin
    reset = 1; req_valid = 0; req_store = 0; req_byte = 0; req_ind = 0; req_addr = 0; req_wdata = 0; flush = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    test_reset();
    test_directed();
    test_indirect();
    test_flush();
    test_reset_mid_ptr();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
